ui_panel_layer: RTL and testbench
=================================

// Module: ui_panel_layer
// PURPOSE
//  Parametrised background/UI compositor; next generation of the fixed six-box Sokoban bottom layer.
//  Draws N_BTN rectangular buttons with borders over background-ROM pixels.
//  Adds keyboard-driven selection (wrap-around), a press flash animation and a latency-aligned pipeline.
//  Sits between the VGA timing/coordinate generator and the layer mixer; text glyph bits come from external renderers.
// PARAMETERS
//  N_BTN        4   number of buttons (2..8); index 0 has highest overlap priority
//  ROM_LAT      1   background ROM read latency in cycles (1..3)
//  BORDER       5   border width in pixels outside each button rectangle
//  FLASH_FRAMES 8   frames the fill flashes after an accepted press (1..255)
//  BLINK_FRAMES 16  frames per half-period of the selected-border blink (1..255)
// PORTS
//  sys_clk      in   1        pixel clock
//  rst          in   1        asynchronous reset, active-high
//  x_pos,y_pos  in   10 each  current pixel coordinate
//  frame_start  in   1        one-cycle pulse at the start of each frame
//  btn_rect     in   40*N_BTN per button {left,right,up,down}, 10 bits each, inclusive bounds
//  btn_en       in   N_BTN    1 = button enabled
//  glyph_pix    in   N_BTN    glyph bit for each button at (x_pos,y_pos), same cycle as the coordinate
//  bg_rgb       in   24       {R,G,B} from background ROM, ROM_LAT cycles after addr={y_pos[6:0],x_pos[6:0]}
//  bg_addr      out  15       combinational ROM address {y_pos[6:0],x_pos[6:0]}
//  sel_prev     in   1        one-cycle pulse: move the selection down one index
//  sel_next     in   1        one-cycle pulse: move the selection up one index
//  sel_press    in   1        one-cycle pulse: activate the selected button
//  Red0,Green0,Blue0 out 8 each composited colour
//  RqFlag0      out  1        output pixel valid
//  sel_idx      out  3        currently selected button
//  press_valid  out  1        one-cycle pulse: a press was accepted
//  press_idx    out  3        index of the accepted press, held until the next press
// BEHAVIOUR
//  Reset outputs: RGB=0, RqFlag0=0, sel_idx=0, press_valid=0, press_idx=0, flash_cnt=0.
//  Pipeline:
//   - Stage 0 registers the per-button inside/border hit vectors and glyph_pix.
//   - A delay line aligns stage 0 with bg_rgb.
//   - The RGB output register gives total latency coordinate->RGB = ROM_LAT+1 cycles.
//   - RqFlag0 goes to 1 ROM_LAT+1 cycles after rst deasserts and stays 1.
//  Hit tests:
//   - inside: left<=x<=right && up<=y<=down.
//   - border: inside the rectangle grown by BORDER on all sides, but not inside.
//   - Bound arithmetic is 11-bit; expansion saturates at 0 and 1023.
//   - The lowest index whose inside or border test hits owns the pixel.
//  Colour priority for the owning button b (first match wins):
//   1. inside && glyph_pix[b] -> 1/25/53
//   2. inside && b==sel_idx && flash_cnt!=0 -> 255/255/255
//   3. inside && !btn_en[b] -> 128/128/128
//   4. inside -> 55/198/192
//   5. border && b==sel_idx && hl_on -> 255/200/0
//   6. border -> 29/176/184
//   7. otherwise (no owning button) -> bg_rgb
//  Selection:
//   - sel_next: sel_idx = (sel_idx==N_BTN-1) ? 0 : sel_idx+1. sel_prev wraps N_BTN-1 <-> 0.
//   - Both pulses in the same cycle, or any navigation while flash_cnt!=0: no change.
//   - Disabled buttons remain selectable.
//  Press:
//   - Accepted when sel_press=1, btn_en[sel_idx]=1 and flash_cnt==0.
//   - Next cycle: press_valid=1, press_idx=sel_idx, flash_cnt=FLASH_FRAMES.
//   - Otherwise the press is ignored with no pulse.
//   - sel_press together with sel_prev/next: the press uses the old sel_idx; navigation is suppressed.
//  flash_cnt decrements on frame_start when nonzero; there is no underflow.
//  The RGB pipeline free-runs; rst mid-frame clears all state and output within 0 cycles (async).
// CONFIGURATION
//  UI_BLINK_EN defined:
//   - blink_cnt counts frame_start pulses 0..BLINK_FRAMES-1; each wrap toggles hl_on.
//   - Reset and any sel_idx change set hl_on=1 and blink_cnt=0.
//  UI_BLINK_EN undefined: hl_on is constantly 1 and no blink counter exists.
// TESTING
//  1. rst pulse, then a pixel at (0,0) with no button there -> RGB matches bg_rgb 2 cycles later; RqFlag0 rises at cycle 2.
//  2. btn0 {100,200,50,80}, glyph=0, sel_idx=1:
//     x=150,y=60 -> 55/198/192; x=97,y=60 -> 29/176/184; x=94 -> bg.
//  3. sel_idx=0: three sel_next pulses with N_BTN=4 -> 1,2,3; fourth -> 0; sel_prev at 0 -> 3; prev+next together -> unchanged.
//  4. sel_press at sel_idx=2, btn_en=4'b1111:
//     - press_valid 1 cycle, press_idx=2; btn2 fill 255/255/255 for 8 frames, then 55/198/192.
//     - A second press during the flash gives no pulse.
//  5. btn_en[1]=0, sel_idx=1, sel_press -> no press_valid; btn1 fill 128/128/128.
//  6. UI_BLINK_EN, BLINK_FRAMES=2: the selected border alternates 255/200/0 and 29/176/184 every 2 frames;
//     sel_next restores hl_on=1 immediately.

Source files
------------

// File: rtl/ui_panel_layer_if.sv
// ui_panel_layer_if: pixel, ROM, navigation and colour-output bundle for the UI panel compositor
interface ui_panel_layer_if #(
    parameter int N_BTN = 4
);
    logic [9:0]          x_pos;
    logic [9:0]          y_pos;
    logic                frame_start;
    logic [40*N_BTN-1:0] btn_rect;
    logic [N_BTN-1:0]    btn_en;
    logic [N_BTN-1:0]    glyph_pix;
    logic [23:0]         bg_rgb;
    logic [14:0]         bg_addr;
    logic                sel_prev;
    logic                sel_next;
    logic                sel_press;
    logic [7:0]          Red0;
    logic [7:0]          Green0;
    logic [7:0]          Blue0;
    logic                RqFlag0;
    logic [2:0]          sel_idx;
    logic                press_valid;
    logic [2:0]          press_idx;

    modport master (
        output x_pos, y_pos, frame_start, btn_rect, btn_en, glyph_pix, bg_rgb,
               sel_prev, sel_next, sel_press,
        input  bg_addr, Red0, Green0, Blue0, RqFlag0, sel_idx, press_valid, press_idx
    );

    modport slave (
        input  x_pos, y_pos, frame_start, btn_rect, btn_en, glyph_pix, bg_rgb,
               sel_prev, sel_next, sel_press,
        output bg_addr, Red0, Green0, Blue0, RqFlag0, sel_idx, press_valid, press_idx
    );
endinterface

// File: rtl/ui_panel_layer.sv
// ui_panel_layer: N_BTN bordered buttons over background ROM pixels with selection, press flash and optional border blink (UI_BLINK_EN)
module ui_panel_layer #(
    parameter int N_BTN        = 4,
    parameter int ROM_LAT      = 1,
    parameter int BORDER       = 5,
    parameter int FLASH_FRAMES = 8,
    parameter int BLINK_FRAMES = 16
) (
    input logic         sys_clk,
    input logic         rst,
    ui_panel_layer_if.slave bus
);
    localparam int          W    = 3 * N_BTN;
    localparam logic [10:0] BW   = 11'(BORDER);
    localparam logic [2:0]  LAST = 3'(N_BTN - 1);

    function automatic logic [10:0] grow_lo(input logic [10:0] v);
        return (v >= BW) ? v - BW : 11'd0;
    endfunction

    function automatic logic [10:0] grow_hi(input logic [10:0] v);
        return (v + BW > 11'd1023) ? 11'd1023 : v + BW;
    endfunction

    // returns {border, inside} for one {left,right,up,down} rectangle
    function automatic logic [1:0] hit_test(input logic [39:0] rc, input logic [9:0] xp, input logic [9:0] yp);
        logic [10:0] x, y, l, r, u, d;
        logic        ins, grown;
        x     = {1'b0, xp};
        y     = {1'b0, yp};
        l     = {1'b0, rc[39:30]};
        r     = {1'b0, rc[29:20]};
        u     = {1'b0, rc[19:10]};
        d     = {1'b0, rc[9:0]};
        ins   = x >= l && x <= r && y >= u && y <= d;
        grown = x >= grow_lo(l) && x <= grow_hi(r) && y >= grow_lo(u) && y <= grow_hi(d);
        return {grown && !ins, ins};
    endfunction

    logic [N_BTN-1:0] ins_c, brd_c;
    logic [W-1:0]     dl_d [ROM_LAT];
    logic [W-1:0]     dl_q [ROM_LAT];
    logic [N_BTN-1:0] ins_a, brd_a, gly_a;
    logic [7:0]       ins8, brd8, gly8, en8;
    logic [2:0]       own_c;
    logic             hit_c, in_o, gly_o, sel_o;
    logic [23:0]      rgb_d, rgb_q;
    logic [ROM_LAT:0] vld_d, vld_q;
    logic [2:0]       sel_d, sel_q, pidx_d, pidx_q;
    logic             pv_d, pv_q, nav, press, hl_on;
    logic [7:0]       flash_d, flash_q;

    assign bus.bg_addr     = {1'b0, bus.y_pos[6:0], bus.x_pos[6:0]};
    assign bus.Red0        = rgb_q[23:16];
    assign bus.Green0      = rgb_q[15:8];
    assign bus.Blue0       = rgb_q[7:0];
    assign bus.RqFlag0     = vld_q[ROM_LAT];
    assign bus.sel_idx     = sel_q;
    assign bus.press_valid = pv_q;
    assign bus.press_idx   = pidx_q;

    // per-button hit tests on the incoming coordinate
    always_comb begin
        ins_c = '0;
        brd_c = '0;
        for (int i = 0; i < N_BTN; i++) begin
            {brd_c[i], ins_c[i]} = hit_test(bus.btn_rect[40*i +: 40], bus.x_pos, bus.y_pos);
        end
    end

    // stage 0 captures hits and glyph bits, later stages delay them to meet bg_rgb
    always_comb begin
        dl_d[0] = {bus.glyph_pix, brd_c, ins_c};
        for (int k = 1; k < ROM_LAT; k++) begin
            dl_d[k] = dl_q[k-1];
        end
    end

    assign {gly_a, brd_a, ins_a} = dl_q[ROM_LAT-1];
    assign ins8 = 8'(ins_a);
    assign brd8 = 8'(brd_a);
    assign gly8 = 8'(gly_a);
    assign en8  = 8'(bus.btn_en);

    // lowest-index button hitting inside or border owns the pixel
    always_comb begin
        own_c = 3'd0;
        hit_c = 1'b0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (ins_a[i] || brd_a[i]) begin
                own_c = 3'(i);
                hit_c = 1'b1;
            end
        end
    end

    assign in_o  = ins8[own_c];
    assign gly_o = gly8[own_c];
    assign sel_o = own_c == sel_q;

    // colour priority for the owning button, background when nothing owns the pixel
    always_comb begin
        rgb_d = !hit_c                              ? bus.bg_rgb  :
                (in_o && gly_o)                     ? 24'h011935 :
                (in_o && sel_o && flash_q != 8'd0)  ? 24'hFFFFFF :
                (in_o && !en8[own_c])               ? 24'h808080 :
                in_o                                ? 24'h37C6C0 :
                (brd8[own_c] && sel_o && hl_on)     ? 24'hFFC800 :
                                                      24'h1DB0B8;
        vld_d = {vld_q[ROM_LAT-1:0], 1'b1};
    end

    // selection, press acceptance and flash countdown
    always_comb begin
        nav     = !bus.sel_press && flash_q == 8'd0 && (bus.sel_next ^ bus.sel_prev);
        press   = bus.sel_press && en8[sel_q] && flash_q == 8'd0;
        sel_d   = !nav         ? sel_q :
                  bus.sel_next ? (sel_q == LAST ? 3'd0 : sel_q + 3'd1) :
                                 (sel_q == 3'd0 ? LAST : sel_q - 3'd1);
        pv_d    = press;
        pidx_d  = press ? sel_q : pidx_q;
        flash_d = press                                   ? 8'(FLASH_FRAMES) :
                  (bus.frame_start && flash_q != 8'd0)    ? flash_q - 8'd1 :
                                                            flash_q;
    end

    // pipeline and control state registers
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ROM_LAT; k++) dl_q[k] <= '0;
            rgb_q   <= '0;
            vld_q   <= '0;
            sel_q   <= '0;
            pv_q    <= 1'b0;
            pidx_q  <= '0;
            flash_q <= '0;
        end else begin
            for (int k = 0; k < ROM_LAT; k++) dl_q[k] <= dl_d[k];
            rgb_q   <= rgb_d;
            vld_q   <= vld_d;
            sel_q   <= sel_d;
            pv_q    <= pv_d;
            pidx_q  <= pidx_d;
            flash_q <= flash_d;
        end
    end

`ifdef UI_BLINK_EN
    logic       hl_d, hl_q, sel_chg, wrap;
    logic [7:0] blink_cnt_d, blink_cnt_q;

    assign hl_on = hl_q;

    // blink phase restarts lit on every selection change
    always_comb begin
        sel_chg     = sel_d != sel_q;
        wrap        = bus.frame_start && blink_cnt_q == 8'(BLINK_FRAMES - 1);
        blink_cnt_d = sel_chg         ? 8'd0 :
                      wrap            ? 8'd0 :
                      bus.frame_start ? blink_cnt_q + 8'd1 :
                                        blink_cnt_q;
        hl_d        = sel_chg ? 1'b1 : wrap ? !hl_q : hl_q;
    end

    // blink state registers
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            hl_q        <= 1'b1;
            blink_cnt_q <= '0;
        end else begin
            hl_q        <= hl_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end
`else
    assign hl_on = BLINK_FRAMES > 0;
`endif
endmodule

// File: tb/tb_ui_panel_layer.sv
// tb_ui_panel_layer: scoreboard bench for ui_panel_layer (handles UI_BLINK_EN defined or not)
module tb_ui_panel_layer;
    localparam int N   = 4;
    localparam int LAT = 1;
    localparam int BF  = 2;

    localparam logic [23:0] C_GLY = 24'h011935;
    localparam logic [23:0] C_WHT = 24'hFFFFFF;
    localparam logic [23:0] C_DIS = 24'h808080;
    localparam logic [23:0] C_FIL = 24'h37C6C0;
    localparam logic [23:0] C_HL  = 24'hFFC800;
    localparam logic [23:0] C_BRD = 24'h1DB0B8;

    typedef struct {
        bit          v;
        logic [23:0] e;
        string       tag;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    ent_t sbq[$];

    always #5 clk = ~clk;

    ui_panel_layer_if #(.N_BTN(N)) bus();

    ui_panel_layer #(
        .N_BTN(N), .ROM_LAT(LAT), .BORDER(5), .FLASH_FRAMES(8), .BLINK_FRAMES(BF)
    ) dut (
        .sys_clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [23:0] rom(input logic [14:0] a);
        return {a[7:0], a[14:7], ~a[7:0]};
    endfunction

    function automatic logic [23:0] bgx(input int x, input int y);
        return rom({1'b0, 7'(y), 7'(x)});
    endfunction

    function automatic logic [39:0] rect(input int l, input int r, input int u, input int d);
        return {10'(l), 10'(r), 10'(u), 10'(d)};
    endfunction

    always @(posedge clk) bus.bg_rgb <= rom(bus.bg_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input bit v, input logic [23:0] e, input string tag);
        ent_t n;
        n.v   = v;
        n.e   = e;
        n.tag = tag;
        sbq.push_back(n);
    endtask

    task automatic tick();
        @(negedge clk);
        if (sbq.size() == LAT + 1) begin
            ent_t e = sbq.pop_front();
            if (e.v) chk(e.tag, 32'({bus.Red0, bus.Green0, bus.Blue0}), 32'(e.e));
        end
    endtask

    task automatic idle();
        tick();
        bus.x_pos     = 10'd1023;
        bus.y_pos     = 10'd1023;
        bus.glyph_pix = '0;
        push(0, '0, "");
    endtask

    task automatic px(input int x, input int y, input logic [3:0] g, input logic [23:0] e, input string tag);
        tick();
        bus.x_pos     = 10'(x);
        bus.y_pos     = 10'(y);
        bus.glyph_pix = g;
        push(1, e, tag);
    endtask

    task automatic ctl(input bit p, input bit n, input bit s, input bit f);
        idle();
        {bus.sel_prev, bus.sel_next, bus.sel_press, bus.frame_start} = {p, n, s, f};
        idle();
        {bus.sel_prev, bus.sel_next, bus.sel_press, bus.frame_start} = 4'b0000;
    endtask

    function automatic logic [23:0] blink_exp(input int k);
`ifdef UI_BLINK_EN
        return ((k / BF) % 2 == 0) ? C_HL : C_BRD;
`else
        return (k >= 0) ? C_HL : C_BRD;
`endif
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        bus.x_pos       = 10'd1023;
        bus.y_pos       = 10'd1023;
        bus.frame_start = 1'b0;
        bus.sel_prev    = 1'b0;
        bus.sel_next    = 1'b0;
        bus.sel_press   = 1'b0;
        bus.glyph_pix   = '0;
        bus.btn_en      = 4'b1111;
        bus.btn_rect    = {rect(2, 1020, 300, 320), rect(500, 600, 50, 80),
                           rect(190, 400, 50, 80), rect(100, 200, 50, 80)};
        repeat (3) @(negedge clk);
        chk("rst_rgb", 32'({bus.Red0, bus.Green0, bus.Blue0}), 0);
        chk("rst_rq", 32'(bus.RqFlag0), 0);
        chk("rst_sel", 32'(bus.sel_idx), 0);
        chk("rst_pv", 32'(bus.press_valid), 0);
        chk("rst_pidx", 32'(bus.press_idx), 0);

        @(negedge clk);
        rst = 1'b0;
        bus.x_pos = 10'd0;
        bus.y_pos = 10'd0;
        push(1, bgx(0, 0), "bg00");
        idle();
        chk("rq_c1", 32'(bus.RqFlag0), 0);
        idle();
        chk("rq_c2", 32'(bus.RqFlag0), 1);

        ctl(0, 1, 0, 0);
        chk("sel_to1", 32'(bus.sel_idx), 1);
        px(150, 60, 4'b0000, C_FIL, "in0");
        px(97, 60, 4'b0000, C_BRD, "brd0");
        px(94, 60, 4'b0000, bgx(94, 60), "out0");
        px(95, 60, 4'b0000, C_BRD, "brd0_edge");
        px(150, 85, 4'b0000, C_BRD, "brd0_down");
        px(150, 86, 4'b0000, bgx(150, 86), "out0_down");
        px(150, 60, 4'b0001, C_GLY, "glyph0");
        px(195, 60, 4'b0010, C_FIL, "ovl_in");
        px(203, 60, 4'b0000, C_BRD, "ovl_brd");
        px(300, 60, 4'b0000, C_FIL, "in1_sel");
        px(402, 60, 4'b0000, C_HL, "brd1_sel");
        px(0, 310, 4'b0000, C_BRD, "sat_lo");
        px(1023, 310, 4'b0000, C_BRD, "sat_hi");
        px(500, 295, 4'b0000, C_BRD, "brd3_up");
        px(500, 294, 4'b0000, bgx(500, 294), "out3_up");

        ctl(1, 0, 0, 0);
        chk("prev_to0", 32'(bus.sel_idx), 0);
        for (int k = 1; k <= 4; k++) begin
            ctl(0, 1, 0, 0);
            chk("next_wrap", 32'(bus.sel_idx), k % 4);
        end
        ctl(1, 0, 0, 0);
        chk("prev_wrap", 32'(bus.sel_idx), 3);
        ctl(1, 1, 0, 0);
        chk("both_nav", 32'(bus.sel_idx), 3);
        ctl(0, 1, 0, 0);
        ctl(0, 1, 0, 0);
        ctl(0, 1, 0, 0);
        chk("sel_to2", 32'(bus.sel_idx), 2);

        ctl(0, 0, 1, 0);
        chk("press_pv", 32'(bus.press_valid), 1);
        chk("press_idx", 32'(bus.press_idx), 2);
        idle();
        chk("press_pulse", 32'(bus.press_valid), 0);
        px(550, 60, 4'b0000, C_WHT, "flash0");
        ctl(0, 1, 0, 0);
        chk("nav_in_flash", 32'(bus.sel_idx), 2);
        ctl(0, 0, 1, 0);
        chk("press_in_flash", 32'(bus.press_valid), 0);
        for (int k = 1; k <= 8; k++) begin
            ctl(0, 0, 0, 1);
            px(550, 60, 4'b0000, (k < 8) ? C_WHT : C_FIL, (k < 8) ? "flash_on" : "flash_end");
        end

        ctl(0, 1, 1, 0);
        chk("pn_pv", 32'(bus.press_valid), 1);
        chk("pn_idx", 32'(bus.press_idx), 2);
        chk("pn_sel", 32'(bus.sel_idx), 2);
        for (int k = 1; k <= 8; k++) ctl(0, 0, 0, 1);
        px(550, 60, 4'b0000, C_FIL, "flash_done");

        bus.btn_en = 4'b1101;
        ctl(1, 0, 0, 0);
        chk("sel_dis", 32'(bus.sel_idx), 1);
        ctl(0, 0, 1, 0);
        chk("dis_pv", 32'(bus.press_valid), 0);
        chk("dis_pidx", 32'(bus.press_idx), 2);
        px(300, 60, 4'b0000, C_DIS, "dis_fill");

        for (int k = 1; k <= 6; k++) begin
            ctl(0, 0, 0, 1);
            px(402, 60, 4'b0000, blink_exp(k), "blink");
        end
        ctl(0, 1, 0, 0);
        px(602, 60, 4'b0000, C_HL, "blink_restart");

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_sel", 32'(bus.sel_idx), 0);
        chk("arst_pidx", 32'(bus.press_idx), 0);
        chk("arst_rq", 32'(bus.RqFlag0), 0);
        chk("arst_rgb", 32'({bus.Red0, bus.Green0, bus.Blue0}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
